// File: rtl/vadd_pg_stage_if.sv
// Operand/result bundle for the vector add/sub generate-propagate stage.
// The DUT connects through the slave view; the upstream/downstream side uses master.
interface vadd_pg_stage_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 6
);
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] src_a_i;
  logic [DATA_W-1:0] src_b_i;
  logic [1:0]        sew_i;
  logic              sub_i;
  logic [TAG_W-1:0]  tag_i;

  logic                valid_o;
  logic                ready_i;
  logic [DATA_W-1:0]   g_o;
  logic [DATA_W-1:0]   p_o;
  logic [DATA_W-1:0]   hs_o;
  logic [DATA_W/8-1:0] cin_o;
  logic [1:0]          sew_o;
  logic [TAG_W-1:0]    tag_o;

  modport master (
    output flush_i, valid_i, src_a_i, src_b_i, sew_i, sub_i, tag_i, ready_i,
    input  ready_o, valid_o, g_o, p_o, hs_o, cin_o, sew_o, tag_o
  );

  modport slave (
    input  flush_i, valid_i, src_a_i, src_b_i, sew_i, sub_i, tag_i, ready_i,
    output ready_o, valid_o, g_o, p_o, hs_o, cin_o, sew_o, tag_o
  );
endinterface

// File: rtl/vadd_pg_stage.sv
// Generate/propagate/half-sum pre-processing for the vector add/sub prefix tree,
// segmented per SEW and registered behind a 2-entry skid buffer.
module vadd_pg_stage #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 6
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  vadd_pg_stage_if.slave   bus
);
  localparam int BYTES = DATA_W / 8;

  typedef struct packed {
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] p;
    logic [DATA_W-1:0] hs;
    logic [BYTES-1:0]  cin;
    logic [1:0]        sew;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t            in_entry;
  entry_t            out_q;
  entry_t            skid_q;
  logic              out_valid;
  logic              skid_valid;
  logic              accept;
  logic              transfer;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] lsb;
  logic [5:0]        pos_mask;

  always_comb begin
    unique case (bus.sew_i)
      2'b00: pos_mask = 6'h07;
      2'b01: pos_mask = 6'h0F;
      2'b10: pos_mask = 6'h1F;
      2'b11: pos_mask = 6'h3F;
    endcase
    b_eff    = bus.sub_i ? ~bus.src_b_i : bus.src_b_i;
    lsb      = '0;
    in_entry = '0;
    // Elements never exceed 64 bits, so the low 6 bits of the index locate element LSBs.
    for (int unsigned i = 0; i < DATA_W; i++) begin
      lsb[i] = ((6'(i) & pos_mask) == 6'd0);
    end
    in_entry.hs = bus.src_a_i ^ b_eff;
    in_entry.g  = (bus.src_a_i & b_eff) | (lsb & in_entry.hs & {DATA_W{bus.sub_i}});
    in_entry.p  = (bus.src_a_i | b_eff) & ~lsb;
    for (int unsigned k = 0; k < BYTES; k++) begin
      in_entry.cin[k] = lsb[8*k] & bus.sub_i;
    end
    in_entry.sew = bus.sew_i;
    in_entry.tag = bus.tag_i;
  end

  assign accept   = bus.valid_i & ~skid_valid;
  assign transfer = out_valid & bus.ready_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (bus.flush_i) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (transfer && skid_valid) begin
      // ready_o is low whenever SKID is occupied, so no accept can coincide here.
      out_q      <= skid_q;
      skid_valid <= 1'b0;
    end else if (accept && (!out_valid || transfer)) begin
      out_q     <= in_entry;
      out_valid <= 1'b1;
    end else if (accept) begin
      skid_q     <= in_entry;
      skid_valid <= 1'b1;
    end else if (transfer) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.ready_o = ~skid_valid;
  assign bus.valid_o = out_valid;
  assign bus.g_o     = out_q.g;
  assign bus.p_o     = out_q.p;
  assign bus.hs_o    = out_q.hs;
  assign bus.cin_o   = out_q.cin;
  assign bus.sew_o   = out_q.sew;
  assign bus.tag_o   = out_q.tag;
endmodule

// File: tb/tb_vadd_pg_stage.sv
// Scoreboard bench for vadd_pg_stage: a driver pushes reference results on accept,
// a separate monitor checks every presented output entry in order.
module tb_vadd_pg_stage;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 6;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  vadd_pg_stage_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  vadd_pg_stage #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  typedef struct {
    logic [63:0] g;
    logic [63:0] p;
    logic [63:0] hs;
    logic [7:0]  cin;
    logic [1:0]  sew;
    logic [5:0]  tag;
  } exp_t;

  exp_t q[$];
  int   checks    = 0;
  int   failures  = 0;
  bit   rand_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: walk element by element, the element LSB takes the carry-in role.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [1:0] sew, input logic sub, input logic [5:0] tag);
    exp_t        r;
    int          esz;
    logic [63:0] bp;
    esz   = 8 << sew;
    bp    = sub ? ~b : b;
    r.hs  = a ^ bp;
    r.g   = a & bp;
    r.p   = a | bp;
    r.cin = '0;
    for (int e = 0; e < 64; e += esz) begin
      r.p[e]       = 1'b0;
      r.g[e]       = r.g[e] | (r.hs[e] & sub);
      r.cin[e / 8] = sub;
    end
    r.sew = sew;
    r.tag = tag;
    return r;
  endfunction

  // Monitor: checks buffer occupancy and the head entry whenever output is valid.
  initial begin
    exp_t h;
    forever begin
      @(negedge clk_i);
      #1;
      if (rstn_i) begin
        chk("ready_o", 64'(bus.ready_o), 64'(q.size() < 2));
        chk("valid_o", 64'(bus.valid_o), 64'(q.size() != 0));
        if (bus.valid_o && q.size() != 0) begin
          h = q[0];
          chk("g_o",   bus.g_o,          h.g);
          chk("p_o",   bus.p_o,          h.p);
          chk("hs_o",  bus.hs_o,         h.hs);
          chk("cin_o", 64'(bus.cin_o),   64'(h.cin));
          chk("sew_o", 64'(bus.sew_o),   64'(h.sew));
          chk("tag_o", 64'(bus.tag_o),   64'(h.tag));
          if (bus.ready_i && !bus.flush_i) void'(q.pop_front());
        end
      end
    end
  end

  // One clock with the inputs already set at this negedge; ends at the next negedge.
  task automatic cycle(output bit acc);
    exp_t e;
    bit   r0;
    if (rand_mode) bus.ready_i = ($urandom_range(0, 9) < 7);
    acc = bus.valid_i && bus.ready_o && !bus.flush_i;
    if (acc) e = model(bus.src_a_i, bus.src_b_i, bus.sew_i, bus.sub_i, bus.tag_i);
    if (rand_mode) begin
      #3;
      r0          = bus.ready_o;
      bus.ready_i = ~bus.ready_i;
      #1;
      chk("ready_o_indep", 64'(bus.ready_o), 64'(r0));
      bus.ready_i = ~bus.ready_i;
    end
    @(posedge clk_i);
    #1;
    if (bus.flush_i) q.delete();
    if (acc) q.push_back(e);
    @(negedge clk_i);
  endtask

  task automatic set_in(input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] sew, input logic sub, input logic [5:0] tag);
    bus.src_a_i = a;
    bus.src_b_i = b;
    bus.sew_i   = sew;
    bus.sub_i   = sub;
    bus.tag_i   = tag;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic [1:0] sew, input logic sub, input logic [5:0] tag);
    bit acc;
    set_in(a, b, sew, sub, tag);
    bus.valid_i = 1'b1;
    for (int n = 0; n < 200; n++) begin
      cycle(acc);
      if (acc) return;
    end
    checks++;
    failures++;
    $display("FAIL accept_timeout actual=not_accepted required=accepted tag=%0d", tag);
  endtask

  task automatic drain();
    bit acc;
    bus.valid_i = 1'b0;
    for (int n = 0; n < 50 && q.size() != 0; n++) cycle(acc);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    set_in(r64(), r64(), 2'b01, 1'b1, 6'h2A);

    // Reset held with live stimulus
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_valid_o", 64'(bus.valid_o), 64'd0);
    chk("rst_ready_o", 64'(bus.ready_o), 64'd1);
    chk("rst_g_o",     bus.g_o,          64'd0);
    chk("rst_p_o",     bus.p_o,          64'd0);
    chk("rst_hs_o",    bus.hs_o,         64'd0);
    chk("rst_cin_o",   64'(bus.cin_o),   64'd0);
    chk("rst_sew_o",   64'(bus.sew_o),   64'd0);
    chk("rst_tag_o",   64'(bus.tag_o),   64'd0);
    @(negedge clk_i);
    bus.valid_i = 1'b0;
    rstn_i      = 1'b1;
    cycle(acc);

    // Byte elements, add
    send(64'h0000_0000_0000_00FF, 64'h1, 2'b00, 1'b0, 6'd1);
    bus.valid_i = 1'b0;
    #1;
    chk("t1_valid_o", 64'(bus.valid_o), 64'd1);
    chk("t1_g0",      64'(bus.g_o[0]),  64'd1);
    chk("t1_p_lsb",   bus.p_o & 64'h0101_0101_0101_0101, 64'd0);
    chk("t1_cin",     64'(bus.cin_o),   64'h00);

    // Word elements, subtract of equal operands
    send(64'h0000_0005_0000_0003, 64'h0000_0005_0000_0003, 2'b10, 1'b1, 6'd2);
    bus.valid_i = 1'b0;
    #1;
    chk("t2_hs",    bus.hs_o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t2_g_lsb", bus.g_o & 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001);
    chk("t2_p_lsb", bus.p_o & 64'h0000_0001_0000_0001, 64'd0);
    chk("t2_cin",   64'(bus.cin_o), 64'h11);

    // Single 64-bit element, 0 - 0
    send(64'd0, 64'd0, 2'b11, 1'b1, 6'd3);
    bus.valid_i = 1'b0;
    #1;
    chk("t3_cin", 64'(bus.cin_o), 64'h01);
    chk("t3_p",   bus.p_o, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t3_g",   bus.g_o, 64'h0000_0000_0000_0001);
    cycle(acc);
    drain();

    // Back-pressure: two fill the buffer, the third stalls
    bus.ready_i = 1'b0;
    send(r64(), r64(), 2'(($urandom_range(0, 3))), 1'b0, 6'd1);
    send(r64(), r64(), 2'(($urandom_range(0, 3))), 1'b1, 6'd2);
    #1;
    chk("full_ready_o", 64'(bus.ready_o), 64'd0);
    chk("full_tag_o",   64'(bus.tag_o),   64'd1);
    set_in(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 2'b01, 1'b1, 6'd3);
    bus.valid_i = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cycle(acc);
      chk("stall_no_accept", 64'(acc), 64'd0);
    end
    bus.ready_i = 1'b1;
    send(64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 2'b01, 1'b1, 6'd3);
    drain();

    // Flush with both entries full and a valid input present
    bus.ready_i = 1'b0;
    send(r64(), r64(), 2'b00, 1'b1, 6'd10);
    send(r64(), r64(), 2'b10, 1'b0, 6'd11);
    set_in(r64(), r64(), 2'b11, 1'b1, 6'd12);
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b1;
    cycle(acc);
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    #1;
    chk("flush_valid_o", 64'(bus.valid_o), 64'd0);
    chk("flush_ready_o", 64'(bus.ready_o), 64'd1);
    bus.ready_i = 1'b1;
    cycle(acc);
    #1;
    chk("flush_no_accept", 64'(bus.valid_o), 64'd0);

    // Asynchronous reset mid-operation
    bus.ready_i = 1'b0;
    send(r64(), r64(), 2'b01, 1'b0, 6'd20);
    send(r64(), r64(), 2'b11, 1'b1, 6'd21);
    bus.valid_i = 1'b0;
    #2;
    rstn_i = 1'b0;
    #1;
    q.delete();
    chk("arst_valid_o", 64'(bus.valid_o), 64'd0);
    chk("arst_ready_o", 64'(bus.ready_o), 64'd1);
    chk("arst_tag_o",   64'(bus.tag_o),   64'd0);
    chk("arst_g_o",     bus.g_o,          64'd0);
    @(negedge clk_i);
    rstn_i      = 1'b1;
    bus.ready_i = 1'b1;
    send(r64(), r64(), 2'b10, 1'b1, 6'd22);
    drain();

    // Random traffic across all element widths
    rand_mode = 1;
    for (int n = 0; n < 1000; n++) begin
      while ($urandom_range(0, 3) == 0) begin
        bus.valid_i = 1'b0;
        set_in(r64(), r64(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 6'($urandom));
        cycle(acc);
      end
      send(r64(), r64(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 6'(n));
    end
    rand_mode   = 0;
    bus.ready_i = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vadd_pg_stage.md
Name: vadd_pg_stage

Overview:
- Pre-processing stage of the vector integer add/sub datapath. Sits directly upstream of the parallel-prefix carry tree.
- Converts two 64-bit source operands into bitwise generate, propagate and half-sum vectors, plus per-byte carry-in bits.
- Segments the vectors at element boundaries according to SEW, so no carry crosses between elements.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so ready_o is a registered signal.

Parameters:
- DATA_W, 64, operand width in bits; must be a multiple of 64.
- TAG_W, 6, width of the sideband tag carried unchanged alongside the data.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush; drops all buffered entries
- valid_i  in  1  upstream operand valid
- ready_o  out  1  stage can accept an operand this cycle
- src_a_i  in  DATA_W  operand A
- src_b_i  in  DATA_W  operand B
- sew_i  in  2  element width: 00=8, 01=16, 10=32, 11=64 bits
- sub_i  in  1  1 = compute A-B, 0 = compute A+B
- tag_i  in  TAG_W  sideband tag
- valid_o  out  1  output entry valid
- ready_i  in  1  downstream prefix tree accepts the entry
- g_o  out  DATA_W  generate vector, carry-in folded in at each element LSB
- p_o  out  DATA_W  propagate vector, forced to 0 at each element LSB
- hs_o  out  DATA_W  half-sum A^B', unmasked
- cin_o  out  DATA_W/8  carry-in per byte; equals sub at each element-LSB byte, 0 elsewhere
- sew_o  out  2  registered sew_i
- tag_o  out  TAG_W  registered tag_i

Behaviour:
- Effective operand: B' = sub_i ? ~src_b_i : src_b_i.
- Element LSB mask: bit i is an element LSB when i mod (8<<sew_i) == 0.
- Bit computation:
  - Non-LSB bits: g = A&B', p = A|B'.
  - LSB bits: g = (A&B') | ((A^B') & sub_i), p = 0.
  - All bits: hs = A^B'.
- cin_o[k] = sub_i when byte k starts an element, else 0.
- Handshake: accept = valid_i & ready_o; transfer = valid_o & ready_i.
- Latency: an accepted operand appears on the outputs in the next cycle (1 cycle).
- Storage: output register (OUT) and skid register (SKID), each with its own valid bit.
- ready_o = ~skid_valid. It is a register output, with no combinational path from ready_i.
- Cycle update, in priority order:
  1. flush_i=1: out_valid=0, skid_valid=0. Input is ignored even if valid_i=1. Data registers hold.
  2. If transfer and skid_valid: SKID moves to OUT, skid_valid=0. No accept is possible in this cycle because ready_o=0.
  3. If accept and (~out_valid or transfer): the new entry loads OUT, out_valid=1.
  4. If accept and out_valid and ~transfer: the new entry loads SKID, skid_valid=1.
  5. If transfer with no refill: out_valid=0.
- OUT data is stable while valid_o=1 and ready_i=0. Entries leave strictly in acceptance order.
- Reset (rstn_i=0, asynchronous assert): valid_o=0, skid_valid=0, ready_o=1; g_o, p_o, hs_o, cin_o, sew_o and tag_o all 0.
- Reset mid-operation discards both entries. The first accept after deassertion is the next entry out.
- Buffer full (both valid, ready_i=0): ready_o=0 and both entries hold indefinitely.
- Simultaneous accept and transfer with OUT valid and SKID empty: OUT is replaced by the new entry, valid_o stays 1, SKID is untouched.

Test Plan:
- Reset with stimulus active -> valid_o=0, ready_o=1, all data outputs 0. Release reset, then A=0x00000000000000FF, B=0x01, sew=00, sub=0 -> next cycle valid_o=1; p_o bits 0,8,...,56 =0; g_o[0]=1; cin_o=0x00.
- A=B=0x0000000500000003, sew=10, sub=1 -> hs_o=0xFFFFFFFFFFFFFFFF; g_o bit0=1 and bit32=1; p_o bits 0 and 32 =0; cin_o=0x11.
- sew=11, sub=1, A=0, B=0 -> cin_o=0x01; p_o=0xFFFFFFFFFFFFFFFE; g_o=0x0000000000000001.
- Back-to-back tags 1,2,3 with ready_i=0 -> tags 1 and 2 accepted, ready_o=0 on the cycle after the 2nd accept, tag 3 stalls. Raise ready_i -> tag_o sequence 1,2,3, no loss or duplication.
- Random valid_i/ready_i over 1000 operands, all SEWs -> the output stream equals a reference model in order; ready_o never depends combinationally on ready_i.
- flush_i with both entries full and valid_i=1 -> next cycle valid_o=0, ready_o=1, and the flushed-cycle input is not accepted.
